imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for the CPU's 64-word instruction memory.
- Receives a framed word stream on a valid/ready interface: a header with the word count N, then N instruction words, then a checksum word.
- Writes each instruction word into the instruction-memory write port and keeps the CPU in reset until the checksum verifies.
- Sits between the host/debug link and the CPU top level. It drives the CPU's active-high reset and the memory write port.

Parameters:
DEPTH, 64, number of instruction-memory words; legal N is 1..DEPTH.
ADDR_W, 6, word-address width; equals log2(DEPTH).
WORD_W, 32, instruction/data word width.

Ports:
clk  input  1  single system clock; all state changes on rising edge.
reset  input  1  reset; asynchronous, active-low.
start  input  1  one-cycle request to begin a load; ignored in HEADER, LOAD and CHECK.
in_valid  input  1  stream word valid.
in_data  input  WORD_W  stream word.
in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid & in_ready.
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
mem_addr  output  ADDR_W  instruction-memory word address.
mem_wdata  output  WORD_W  instruction-memory write data.
cpu_reset  output  1  active-high reset to the CPU; 1 unless a verified image is loaded.
done  output  1  verified image loaded; CPU running.
error  output  1  load failed.
error_code  output  2  0 none, 1 bad header, 2 checksum mismatch.
words_loaded  output  ADDR_W+1  number of instruction words written in the current/last load.

Behaviour:
- Reset (reset low, asynchronous):
  - State enters IDLE immediately.
  - cpu_reset=1; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - done=0; error=0; error_code=0; words_loaded=0.
  - Internal count, address and sum clear to 0.
  - Reset mid-load aborts the frame. Memory contents already written stay as they are.
- FSM states: IDLE, HEADER, LOAD, CHECK, RUN, ERROR (Moore outputs).
  - in_ready=1 only in HEADER, LOAD and CHECK.
  - cpu_reset=0 only in RUN.
  - done=1 only in RUN.
  - error=1 only in ERROR.
- IDLE: start -> HEADER.
- HEADER: on transfer, N=in_data.
  - N==0 or N>DEPTH: -> ERROR with error_code=1.
  - Otherwise latch N, clear address, sum and words_loaded, then -> LOAD.
  - The upper bits of in_data count; 32'h0000_0041 is invalid.
- LOAD: on each transfer:
  - In the next cycle, mem_we=1, mem_addr=current address, mem_wdata=in_data. mem_we lasts exactly one cycle. Write latency is 1 cycle after the handshake.
  - Address increments.
  - sum = (sum + in_data) mod 2^32.
  - words_loaded increments.
  - After the Nth word -> CHECK.
  - Address never exceeds N-1 and never wraps.
  - With no transfer (in_valid=0), state and outputs are held and mem_we=0.
- CHECK: on transfer, compare in_data with sum.
  - Equal: -> RUN. cpu_reset falls and done rises in the cycle after the handshake.
  - Not equal: -> ERROR with error_code=2.
  - The final mem_we pulse for word N-1 occurs in the first CHECK cycle, before any RUN entry.
- RUN: start -> HEADER.
  - cpu_reset=1 and done=0 from the next cycle.
  - The CPU is re-held before any new write.
- ERROR: cpu_reset=1; error_code is held.
  - start -> HEADER; error and error_code clear on that transition.
- in_data is ignored when in_valid=0.
- Checksum covers instruction words only, not the header.

Test Plan:
1. Hold reset low 3 cycles, then release -> cpu_reset=1, in_ready=0, mem_we=0, done=0, error=0, state IDLE. Assert reset mid-LOAD after 2 words -> same values on the same edge. A following start with a full frame loads correctly.
2. Normal load:
   - Stimulus: start; send 3, then 0x20080005, 0x20090003, 0x01095020, then 0x411A5028 back-to-back.
   - Memory: mem_we pulses at addr 0, 1, 2 with those data, each 1 cycle after its handshake.
   - Completion: one cycle after the checksum handshake, cpu_reset=0, done=1, words_loaded=3, in_ready=0.
3. Same frame with checksum 0x411A5029 -> error=1, error_code=2, cpu_reset=1, done=0. A new start clears error and returns to HEADER.
4. Header 0, and separately header 65 -> error_code=1, no mem_we pulse, cpu_reset=1.
5. Gaps and arithmetic:
   - Words with in_valid gaps of 0-3 cycles -> writes only on handshakes, addresses contiguous.
   - Words 0xFFFFFFFF, 0x00000002 with checksum 0x00000001 -> RUN (sum wraps).
   - Full 64-word frame -> last write at addr 63, words_loaded=64.
6. From RUN, pulse start -> cpu_reset=1 and done=0 the next cycle, in_ready=1. A second frame overwrites addr 0 and returns to RUN.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader for the CPU instruction memory. It takes a header holding the word count N,
// then N instruction words, then a checksum word. The CPU stays in reset until the checksum matches.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD, S_CHECK, S_RUN, S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_HEADER  = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;

  state_e              state_q;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   sum_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                cpu_reset_q;
  logic                done_q;
  logic                error_q;
  logic [1:0]          error_code_q;

  logic                xfer;
  logic                hdr_bad;
  logic                last_word;
  logic [ADDR_W:0]     cnt_d;
  logic [WORD_W-1:0]   sum_d;

  always_comb begin
    xfer      = in_valid & in_ready_q;
    // The whole header word is range-checked, so a value with upper bits set is rejected.
    hdr_bad   = (in_data == '0) || (in_data > WORD_W'(DEPTH));
    cnt_d     = cnt_q + (ADDR_W+1)'(1);
    sum_d     = sum_q + in_data;
    last_word = (cnt_d == n_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state_q      <= S_HEADER;
            in_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (hdr_bad) begin
              state_q      <= S_ERROR;
              in_ready_q   <= 1'b0;
              error_q      <= 1'b1;
              error_code_q <= ERR_HEADER;
            end else begin
              state_q <= S_LOAD;
              n_q     <= in_data[ADDR_W:0];
              addr_q  <= '0;
              sum_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= in_data;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            // The address stops at N-1, so a full-depth frame never wraps back to 0.
            if (last_word) state_q <= S_CHECK;
            else           addr_q  <= addr_q + ADDR_W'(1);
          end
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == sum_q) begin
              state_q     <= S_RUN;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q      <= S_ERROR;
              error_q      <= 1'b1;
              error_code_q <= ERR_CHKSUM;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = error_code_q;
  assign words_loaded = cnt_q;

endmodule
